// File: rtl/tlb_lookup.sv
// Fully associative Sv39 data TLB sitting in front of the page-table walker.
// Hits translate in the request cycle; misses walk, refill and answer a cycle after finish.
module tlb_lookup #(
    parameter int ADDR_WIDTH = 64,
    parameter int ENTRY_NUM  = 8,
    parameter int VPN_WIDTH  = 27,
    parameter int PPN_WIDTH  = 44
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] va_from_core,
    input  logic                  request_from_core,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] pa_to_core,
    output logic                  done_to_core,
    output logic                  fault_to_core,
    output logic                  stall_to_core,
    output logic                  request_to_twu,
    output logic [ADDR_WIDTH-1:0] va_to_twu,
    input  logic [ADDR_WIDTH-1:0] pa_from_twu,
    input  logic                  finish_from_twu,
    input  logic                  hit_from_twu
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int PAD_W = ADDR_WIDTH - PPN_WIDTH - 12;

    typedef enum logic [1:0] {IDLE, WALK, RESP} state_e;

    state_e                state_q;
    logic [ENTRY_NUM-1:0]  valid_q;
    logic [VPN_WIDTH-1:0]  vpn_q [ENTRY_NUM];
    logic [PPN_WIDTH-1:0]  ppn_q [ENTRY_NUM];
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [ADDR_WIDTH-1:0] va_q;
    logic [ADDR_WIDTH-1:0] pa_q;
    logic                  fault_q;
    logic                  flush_seen_q;

    logic [VPN_WIDTH-1:0]  va_vpn;
    logic                  hit;
    logic [PPN_WIDTH-1:0]  hit_ppn;
    logic [ADDR_WIDTH-1:0] hit_pa;
    logic [IDX_W-1:0]      victim;
    logic                  all_valid;
    logic                  lookup;
    logic                  hit_done;
    logic                  walk_start;
    logic                  in_resp;
    logic                  refill;

    assign va_vpn = va_from_core[VPN_WIDTH+11:12];

    // Entries never share a VPN, so OR-ing the matching PPNs is a clean mux.
    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (valid_q[i] && vpn_q[i] == va_vpn) begin
                hit     = 1'b1;
                hit_ppn = hit_ppn | ppn_q[i];
            end
        end
    end

    assign hit_pa = {{PAD_W{1'b0}}, hit_ppn, va_from_core[11:0]};

    always_comb begin
        victim    = rr_ptr_q;
        all_valid = &valid_q;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = IDX_W'(i);
        end
    end

    assign lookup     = (state_q == IDLE) && request_from_core && !flush;
    assign hit_done   = lookup && hit;
    assign walk_start = lookup && !hit;
    assign in_resp    = (state_q == RESP);
    assign refill     = (state_q == WALK) && finish_from_twu && hit_from_twu
                        && !flush && !flush_seen_q;

    assign done_to_core   = hit_done || in_resp;
    assign fault_to_core  = in_resp && fault_q;
    assign request_to_twu = walk_start;
    assign va_to_twu      = walk_start ? va_from_core : va_q;

    always_comb begin
        pa_to_core = '0;
        if (hit_done)     pa_to_core = hit_pa;
        else if (in_resp) pa_to_core = pa_q;
    end

    always_comb begin
        stall_to_core = 1'b0;
        unique case (state_q)
            IDLE:    stall_to_core = request_from_core && (flush || !hit);
            WALK:    stall_to_core = 1'b1;
            default: stall_to_core = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            vpn_q        <= '{default: '0};
            ppn_q        <= '{default: '0};
            rr_ptr_q     <= '0;
            va_q         <= '0;
            pa_q         <= '0;
            fault_q      <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            if (flush) valid_q <= '0;
            if (refill) begin
                valid_q[victim] <= 1'b1;
                vpn_q[victim]   <= va_q[VPN_WIDTH+11:12];
                ppn_q[victim]   <= pa_from_twu[PPN_WIDTH+11:12];
                if (all_valid) rr_ptr_q <= rr_ptr_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (walk_start) begin
                        va_q    <= va_from_core;
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    if (flush) flush_seen_q <= 1'b1;
                    if (finish_from_twu) begin
                        pa_q    <= pa_from_twu;
                        fault_q <= !hit_from_twu;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    flush_seen_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_lookup.sv
// Directed bench for tlb_lookup: expected results are queued at stimulus time
// and popped when the TLB signals done.
module tb_tlb_lookup;

    typedef struct packed {
        logic [63:0] pa;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] va_from_core = '0;
    logic        request_from_core = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] pa_to_core;
    logic        done_to_core;
    logic        fault_to_core;
    logic        stall_to_core;
    logic        request_to_twu;
    logic [63:0] va_to_twu;
    logic [63:0] pa_from_twu = '0;
    logic        finish_from_twu = 1'b0;
    logic        hit_from_twu = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   twu_cnt = 0;
    exp_t sbq[$];

    tlb_lookup dut (
        .clk              (clk),
        .rstn             (rstn),
        .va_from_core     (va_from_core),
        .request_from_core(request_from_core),
        .flush            (flush),
        .pa_to_core       (pa_to_core),
        .done_to_core     (done_to_core),
        .fault_to_core    (fault_to_core),
        .stall_to_core    (stall_to_core),
        .request_to_twu   (request_to_twu),
        .va_to_twu        (va_to_twu),
        .pa_from_twu      (pa_from_twu),
        .finish_from_twu  (finish_from_twu),
        .hit_from_twu     (hit_from_twu)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rstn && request_to_twu) twu_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".pa"}, pa_to_core, e.pa);
        chk({tag, ".fault"}, {63'd0, fault_to_core}, {63'd0, e.fault});
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_to_core) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".latency"}, 64'(lat), 64'd1);
        if (lat != 0) pop_check(tag);
        else if (sbq.size() != 0) void'(sbq.pop_front());
    endtask

    task automatic do_miss(input string tag, input logic [63:0] va,
                           input logic [63:0] pa, input logic h,
                           input int ncyc, input logic fl_mid,
                           input logic fl_fin);
        exp_t e;
        @(posedge clk); #1;
        request_from_core = 1'b1;
        va_from_core = va;
        @(negedge clk);
        chk({tag, ".twu_start"}, {63'd0, request_to_twu}, 64'd1);
        chk({tag, ".va_twu0"}, va_to_twu, va);
        chk({tag, ".no_done"}, {63'd0, done_to_core}, 64'd0);
        chk({tag, ".stall0"}, {63'd0, stall_to_core}, 64'd1);
        e.pa = pa;
        e.fault = ~h;
        sbq.push_back(e);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            flush = fl_mid && (i == 0);
            @(negedge clk);
            chk({tag, ".walk_stall"}, {63'd0, stall_to_core}, 64'd1);
            chk({tag, ".walk_twu"}, {63'd0, request_to_twu}, 64'd0);
            chk({tag, ".walk_va"}, va_to_twu, va);
        end
        @(posedge clk); #1;
        flush = fl_fin;
        finish_from_twu = 1'b1;
        pa_from_twu = pa;
        hit_from_twu = h;
        @(negedge clk);
        chk({tag, ".fin_nodone"}, {63'd0, done_to_core}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        finish_from_twu = 1'b0;
        hit_from_twu = 1'b0;
        pa_from_twu = '0;
        wait_done(tag);
        @(posedge clk); #1;
        request_from_core = 1'b0;
    endtask

    task automatic do_hit(input string tag, input logic [63:0] va,
                          input logic [63:0] pa);
        exp_t e;
        @(posedge clk); #1;
        request_from_core = 1'b1;
        va_from_core = va;
        e.pa = pa;
        e.fault = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        chk({tag, ".done"}, {63'd0, done_to_core}, 64'd1);
        chk({tag, ".twu"}, {63'd0, request_to_twu}, 64'd0);
        chk({tag, ".stall"}, {63'd0, stall_to_core}, 64'd0);
        pop_check(tag);
        @(posedge clk); #1;
        request_from_core = 1'b0;
    endtask

    task automatic probe_miss(input string tag, input logic [63:0] va);
        do_miss(tag, va, {va[63:12] ^ 52'h0F00, va[11:0]}, 1'b0, 1,
                1'b0, 1'b0);
    endtask

    initial begin
        #3;
        chk("rst.done", {63'd0, done_to_core}, 64'd0);
        chk("rst.pa", pa_to_core, 64'd0);
        chk("rst.fault", {63'd0, fault_to_core}, 64'd0);
        chk("rst.stall", {63'd0, stall_to_core}, 64'd0);
        chk("rst.twu", {63'd0, request_to_twu}, 64'd0);
        chk("rst.va_twu", va_to_twu, 64'd0);
        #9 rstn = 1'b1;

        twu_cnt = 0;
        do_miss("cold", 64'h8000_1234, 64'h8765_4234, 1'b1, 3,
                1'b0, 1'b0);
        chk("cold.twu_once", 64'(twu_cnt), 64'd1);
        @(negedge clk);
        chk("cold.va_hold", va_to_twu, 64'h8000_1234);
        do_hit("hit", 64'h8000_1234, 64'h8765_4234);
        do_hit("hit_off", 64'h8000_1abc, 64'h8765_4abc);

        do_miss("fault", 64'h4000_0000, 64'h1234_5000, 1'b0, 2,
                1'b0, 1'b0);
        do_miss("fault_rewalk", 64'h4000_0000, 64'h1234_5000, 1'b0, 1,
                1'b0, 1'b0);

        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_idle.stall", {63'd0, stall_to_core}, 64'd0);
        @(posedge clk); #1;
        request_from_core = 1'b1;
        va_from_core = 64'h8000_1234;
        @(negedge clk);
        chk("fl_req.done", {63'd0, done_to_core}, 64'd0);
        chk("fl_req.twu", {63'd0, request_to_twu}, 64'd0);
        chk("fl_req.stall", {63'd0, stall_to_core}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        request_from_core = 1'b0;
        probe_miss("fl_idle.miss", 64'h8000_1234);

        for (int k = 1; k <= 9; k++) begin
            do_miss("fill", (64'(k) << 12) | 64'h010,
                    ((64'h100 + 64'(k)) << 12) | 64'h010, 1'b1, 1,
                    1'b0, 1'b0);
        end
        probe_miss("wrap.vpn1_miss", 64'h0000_1010);
        for (int k = 2; k <= 9; k++) begin
            do_hit("wrap.hit", (64'(k) << 12) | 64'h020,
                   ((64'h100 + 64'(k)) << 12) | 64'h020);
        end
        do_miss("wrap.fillA", 64'h0000_A010, 64'h0010_A010, 1'b1, 1,
                1'b0, 1'b0);
        probe_miss("wrap.vpn2_miss", 64'h0000_2010);
        do_hit("wrap.vpn3_hit", 64'h0000_3010, 64'h0010_3010);
        do_hit("wrap.vpnA_hit", 64'h0000_A010, 64'h0010_A010);

        do_miss("flmid", 64'h5000_0123, 64'h9999_9123, 1'b1, 3,
                1'b1, 1'b0);
        probe_miss("flmid.miss", 64'h5000_0123);
        probe_miss("flmid.old_miss", 64'h0000_3010);
        do_miss("fillC", 64'h6000_0456, 64'hAAAA_A456, 1'b1, 2,
                1'b0, 1'b0);
        do_hit("fillC.hit", 64'h6000_0456, 64'hAAAA_A456);
        do_miss("flfin", 64'h7000_0789, 64'hBBBB_B789, 1'b1, 2,
                1'b0, 1'b1);
        probe_miss("flfin.miss", 64'h7000_0789);
        probe_miss("flfin.c_miss", 64'h6000_0456);

        do_miss("fillD", 64'h12_3456_7abc, 64'h55_5555_5abc, 1'b1, 1,
                1'b0, 1'b0);
        do_hit("fillD.hit", 64'h12_3456_7abc, 64'h55_5555_5abc);
        @(posedge clk); #1;
        request_from_core = 1'b1;
        va_from_core = 64'h22_0000_0def;
        @(negedge clk);
        chk("rstw.twu", {63'd0, request_to_twu}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw.walk_stall", {63'd0, stall_to_core}, 64'd1);
        #2;
        rstn = 1'b0;
        request_from_core = 1'b0;
        #1;
        chk("rstw.done", {63'd0, done_to_core}, 64'd0);
        chk("rstw.stall", {63'd0, stall_to_core}, 64'd0);
        chk("rstw.va_twu", va_to_twu, 64'd0);
        @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        finish_from_twu = 1'b1;
        hit_from_twu = 1'b1;
        pa_from_twu = 64'hDEAD_B000;
        @(negedge clk);
        chk("stray.done", {63'd0, done_to_core}, 64'd0);
        chk("stray.stall", {63'd0, stall_to_core}, 64'd0);
        @(posedge clk); #1;
        finish_from_twu = 1'b0;
        hit_from_twu = 1'b0;
        pa_from_twu = '0;
        @(negedge clk);
        chk("stray.done2", {63'd0, done_to_core}, 64'd0);
        chk("stray.pa", pa_to_core, 64'd0);
        probe_miss("rstw.d_miss", 64'h12_3456_7abc);
        probe_miss("rstw.e_miss", 64'h22_0000_0def);

        chk("sb.empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_lookup.md
Name: tlb_lookup

Overview:
- Fully associative Sv39 data-side TLB placed directly upstream of the page-table walker.
- Translates core virtual addresses in the same cycle on a hit.
- On a miss, latches the VA and pulses a walk request to the walker, then waits for the walker's finish.
- On a valid leaf, refills an entry and returns the physical address to the core; otherwise reports a fault.

Parameters:
ADDR_WIDTH, 64, width of VA/PA buses
ENTRY_NUM, 8, number of TLB entries; power of two, >=2
VPN_WIDTH, 27, Sv39 VPN width (VA[38:12])
PPN_WIDTH, 44, stored PPN width (PA[55:12])

Ports:
clk  input  1  clock
rstn  input  1  reset; asynchronous, active-low
va_from_core  input  ADDR_WIDTH  virtual address; held stable while request_from_core is high and done not yet seen
request_from_core  input  1  translation request (level)
flush  input  1  invalidate all entries (sfence.vma)
pa_to_core  output  ADDR_WIDTH  translated physical address, valid with done_to_core
done_to_core  output  1  translation complete (one-cycle pulse, or combinational on a hit)
fault_to_core  output  1  translation failed; only with done_to_core
stall_to_core  output  1  request pending, not done this cycle
request_to_twu  output  1  one-cycle walk start pulse
va_to_twu  output  ADDR_WIDTH  latched miss VA
pa_from_twu  input  ADDR_WIDTH  walker result {PPN, offset}
finish_from_twu  input  1  walker done (one-cycle)
hit_from_twu  input  1  walker found a valid leaf; sampled with finish

Behaviour:
- Entry fields: valid, vpn[VPN_WIDTH], ppn[PPN_WIDTH].
- Reset: all valid=0, rr_ptr=0, state=IDLE, va latch=0, all outputs 0.
- Lookup (combinational) compares VA[38:12] against all valid entries.
  - At most one entry matches by construction.
  - Hit PA = {zero-extend ppn, VA[11:0]}.
- FSM states: IDLE, WALK, RESP.
- IDLE:
  - request & ~flush & hit -> done_to_core=1, pa_to_core=hit PA, fault=0, same cycle (0-cycle latency); stay IDLE.
  - request & ~flush & miss -> latch VA; request_to_twu=1 for this single cycle; va_to_twu=latched VA from the next cycle on (also driven combinationally in this cycle); go WALK.
  - flush:
    - All valid bits clear at the clock edge.
    - Lookup is suppressed that cycle (no done, no walk start).
    - stall_to_core=request.
- WALK:
  - stall_to_core=1.
  - Wait for finish_from_twu. On finish:
    - Register pa_from_twu and ~hit_from_twu; go RESP.
    - If hit_from_twu & ~flush & ~flush_seen: write victim entry {1, latched VA[38:12], pa_from_twu[55:12]}.
    - hit_from_twu=0 -> no write.
  - flush during WALK: clears valid bits immediately and sets flush_seen; the pending refill is dropped but the result is still returned.
  - flush coincident with finish: flush wins, no entry written.
- RESP:
  - done_to_core=1, pa_to_core=registered PA, fault_to_core=registered fault; one cycle.
  - Return to IDLE; clear flush_seen.
  - Miss latency to done = walk cycles + 1.
- Victim selection:
  - Lowest-index invalid entry if any; rr_ptr unchanged.
  - Otherwise entry rr_ptr, and rr_ptr increments modulo ENTRY_NUM (wrap 7->0) on that write.
- request_from_core dropping during WALK: walk completes, refill occurs, RESP done pulse still issued (the core ignores it).
- request_to_twu is never re-asserted while in WALK/RESP.
- va_to_twu holds the latched VA until the next miss.
- Reset mid-walk: all state returns to reset values asynchronously. A walker finish after reset release is ignored in IDLE (no refill, no done).
- pa_to_core is 0 whenever done_to_core=0.

Test Plan:
- Cold miss:
  - Stimulus: VA=0x0000_0000_8000_1234, walker returns pa=0x0000_0000_8765_4234, hit=1 after 3 cycles.
  - Required: request_to_twu pulses once, va_to_twu=0x80001234, done+pa=0x87654234 one cycle after finish, fault=0.
- Hit after refill: same VA next cycle -> done in the request cycle, pa=0x87654234, no request_to_twu.
- Fault:
  - Stimulus: VA=0x4000_0000, walker finish with hit=0.
  - Required: done & fault=1, no entry written; the same VA re-requested issues a new walk.
- Replacement wrap:
  - Stimulus: 9 distinct VPNs 0x1..0x9 filled sequentially.
  - Required: 9th refill overwrites entry 0 (VPN 0x1), rr_ptr=1; VPN 0x1 misses, VPN 0x2 hits.
- Flush:
  - Stimulus: flush asserted mid-WALK, then again in the same cycle as a finish with hit=1.
  - Required: both cases return done with the PA, no entry written; afterwards every VA misses.
- Reset mid-walk:
  - Stimulus: rstn low in WALK, release, then a stray finish.
  - Required: no done, all entries invalid, next request walks.
